// File: rtl/multicycle_seq.sv
// multicycle_seq: multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB)
// with a bounded memory-wait counter that aborts stalled accesses.
//
// Parameters:
//   MEM_WAIT_MAX  cycles (1..255) a FETCH or MEM access may wait for mem_ready
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   Opcode, Function_opcode instruction[31:26] / [5:0], valid from DECODE on
//   Zero                    ALU zero flag (used in EXEC)
//   mem_ready               memory completes the current access this cycle
//   PCWrite, PCSrc          PC update enable / source (00 +4, 01 br, 10 j, 11 jr)
//   IRWrite                 instruction register load
//   MemRead, MemWrite       memory requests
//   RegWrite                register file write enable
//   state                   current state (0 FETCH .. 4 WB)
//   instr_done              one-cycle retire pulse
//   err                     one-cycle pulse on illegal opcode or memory timeout
//
// Optional feature (macro SEQ_PERF_CNT_EN):
//   cycle_count, instr_count  32-bit wrapping clock / retire counters
module multicycle_seq #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Function_opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  state_t     cur, nxt;
  logic [7:0] wait_cnt;
  logic [5:0] op_q, fn_q;
  logic [5:0] op_cur, fn_cur;
  logic       wait_last;
  logic       timeout;

  // DECODE decides on the live instruction fields; every later state uses
  // the copies captured at the end of DECODE.
  assign op_cur = (cur == DECODE) ? Opcode : op_q;
  assign fn_cur = (cur == DECODE) ? Function_opcode : fn_q;

  // This waiting cycle is the MEM_WAIT_MAX-th one: abort unless memory answers.
  assign wait_last = !mem_ready && (wait_cnt == WAIT_LIMIT - 8'd1);

  assign state = cur;

  always_comb begin
    nxt        = cur;
    timeout    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 2'b00;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    err        = 1'b0;
    if (reset) begin
      // state is held at FETCH; suppress everything except its read request
      MemRead = 1'b1;
    end else begin
      unique case (cur)
        FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            nxt     = DECODE;
          end else if (wait_last) begin
            err     = 1'b1;
            timeout = 1'b1;
            nxt     = FETCH;
          end
        end
        DECODE: begin
          unique case (op_cur)
            OP_J: begin
              PCWrite    = 1'b1;
              PCSrc      = 2'b10;
              instr_done = 1'b1;
              nxt        = FETCH;
            end
            OP_JAL: begin
              PCWrite    = 1'b1;
              PCSrc      = 2'b10;
              RegWrite   = 1'b1;
              instr_done = 1'b1;
              nxt        = FETCH;
            end
            OP_RTYPE: begin
              if (fn_cur == FN_JR) begin
                PCWrite    = 1'b1;
                PCSrc      = 2'b11;
                instr_done = 1'b1;
                nxt        = FETCH;
              end else begin
                nxt = EXEC;
              end
            end
            OP_BEQ, OP_BNE, OP_LW, OP_SW: nxt = EXEC;
            default: begin
              if (op_cur[5:3] == 3'b001) begin
                nxt = EXEC;
              end else begin
                err = 1'b1;
                nxt = FETCH;
              end
            end
          endcase
        end
        EXEC: begin
          unique case (op_cur)
            OP_BEQ: begin
              PCWrite    = Zero;
              PCSrc      = 2'b01;
              instr_done = 1'b1;
              nxt        = FETCH;
            end
            OP_BNE: begin
              PCWrite    = !Zero;
              PCSrc      = 2'b01;
              instr_done = 1'b1;
              nxt        = FETCH;
            end
            OP_LW, OP_SW: nxt = MEM;
            default:      nxt = WB;
          endcase
        end
        MEM: begin
          if (op_cur == OP_LW) begin
            MemRead = 1'b1;
          end else begin
            MemWrite = 1'b1;
          end
          if (mem_ready) begin
            if (op_cur == OP_LW) begin
              nxt = WB;
            end else begin
              instr_done = 1'b1;
              nxt        = FETCH;
            end
          end else if (wait_last) begin
            err     = 1'b1;
            timeout = 1'b1;
            nxt     = FETCH;
          end
        end
        WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          nxt        = FETCH;
        end
        default: nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur      <= FETCH;
      wait_cnt <= '0;
      op_q     <= '0;
      fn_q     <= '0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) begin
        op_q <= Opcode;
        fn_q <= Function_opcode;
      end
      // Every state change (and a timeout re-entering FETCH) starts a fresh
      // count, so the counter is zero on entry to FETCH and MEM.
      if (timeout || (nxt != cur)) begin
        wait_cnt <= '0;
      end else if (((cur == FETCH) || (cur == MEM)) && !mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (instr_done) begin
        instr_count <= instr_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: reset behaviour, a table of
// instruction scenarios with hand-derived latencies, hand-written corner
// sequences, and randomized instructions against a transaction-level model.
module tb_multicycle_seq;

  localparam int unsigned MAXW = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Function_opcode;
  logic       Zero, mem_ready;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, instr_done, err;
  logic [1:0] PCSrc;
  logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  int checks = 0;
  int failures = 0;

  multicycle_seq #(.MEM_WAIT_MAX(MAXW)) dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .Function_opcode(Function_opcode),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .state(state), .instr_done(instr_done), .err(err)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // {state, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, instr_done, err}
  function automatic logic [11:0] outv();
    return {state, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, instr_done, err};
  endfunction

  function automatic logic [11:0] mk(input logic [2:0] st, input logic pcw, input logic [1:0] src,
                                     input logic irw, input logic mr, input logic mw,
                                     input logic rw, input logic dn, input logic er);
    return {st, pcw, src, irw, mr, mw, rw, dn, er};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd35, 6'd43: return 1'b1;
      default: return (op[5:3] == 3'b001);
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic        mr;
    logic [11:0] exp;
  } cyc_t;
  cyc_t q[$];

  function automatic void push(input logic mr, input logic [11:0] e);
    cyc_t c;
    c.mr = mr;
    c.exp = e;
    q.push_back(c);
  endfunction

  function automatic logic dc();
    return 1'($urandom_range(0, 1));
  endfunction

  // Builds the expected per-cycle trace of one instruction starting in FETCH,
  // given fetch waits fw and memory waits mw.
  function automatic void model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                      input int fw, input int mw);
    logic lw;
    q.delete();
    for (int i = 0; i < fw && i < int'(MAXW); i++) begin
      if (i == int'(MAXW) - 1) begin
        push(1'b0, mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
        return;
      end
      push(1'b0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    end
    push(1'b1, mk(0, 1, 0, 1, 1, 0, 0, 0, 0));
    if (op == 6'd2) begin push(dc(), mk(1, 1, 2, 0, 0, 0, 0, 1, 0)); return; end
    if (op == 6'd3) begin push(dc(), mk(1, 1, 2, 0, 0, 0, 1, 1, 0)); return; end
    if (op == 6'd0 && fn == 6'd8) begin push(dc(), mk(1, 1, 3, 0, 0, 0, 0, 1, 0)); return; end
    if (!is_legal(op)) begin push(dc(), mk(1, 0, 0, 0, 0, 0, 0, 0, 1)); return; end
    push(dc(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    if (op == 6'd4) begin push(dc(), mk(2, z, 1, 0, 0, 0, 0, 1, 0)); return; end
    if (op == 6'd5) begin push(dc(), mk(2, !z, 1, 0, 0, 0, 0, 1, 0)); return; end
    push(dc(), mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
    if (op != 6'd35 && op != 6'd43) begin
      push(dc(), mk(4, 0, 0, 0, 0, 0, 1, 1, 0));
      return;
    end
    lw = (op == 6'd35);
    for (int i = 0; i < mw && i < int'(MAXW); i++) begin
      if (i == int'(MAXW) - 1) begin
        push(1'b0, mk(3, 0, 0, 0, lw, !lw, 0, 0, 1));
        return;
      end
      push(1'b0, mk(3, 0, 0, 0, lw, !lw, 0, 0, 0));
    end
    push(1'b1, mk(3, 0, 0, 0, lw, !lw, 0, !lw, 0));
    if (lw) push(dc(), mk(4, 0, 0, 0, 0, 0, 1, 1, 0));
  endfunction

  task automatic run_model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    model_instr(op, fn, z, fw, mw);
    Opcode = op;
    Function_opcode = fn;
    Zero = z;
    foreach (q[i]) begin
      mem_ready = q[i].mr;
      #2;
      check("rand_cycle", {20'd0, outv()}, {20'd0, q[i].exp});
      tick();
    end
  endtask

  // ---------------- table-driven scenarios ----------------
  typedef struct {
    string      name;
    logic [5:0] op, fn;
    logic       z;
    int         fw, mw;
    int         cyc, pcw, rw, dn, er, src;
  } vec_t;

  function automatic vec_t mkv(input string n, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input int fw, input int mw, input int cyc,
                               input int pcw, input int rw, input int dn, input int er,
                               input int src);
    vec_t v;
    v.name = n; v.op = op; v.fn = fn; v.z = z; v.fw = fw; v.mw = mw;
    v.cyc = cyc; v.pcw = pcw; v.rw = rw; v.dn = dn; v.er = er; v.src = src;
    return v;
  endfunction

  // mem_ready is held low for the first fw FETCH cycles and mw MEM cycles;
  // the instruction ends on the first instr_done or err.
  task automatic run_vec(input vec_t v);
    int fcnt, mcnt, cyc, pcw, rw, dn, er, src;
    bit fin;
    fcnt = 0; mcnt = 0; cyc = 0; pcw = 0; rw = 0; dn = 0; er = 0; src = 0; fin = 0;
    Opcode = v.op;
    Function_opcode = v.fn;
    Zero = v.z;
    while (!fin && cyc < 64) begin
      if (state == 3'd0)      mem_ready = (fcnt >= v.fw);
      else if (state == 3'd3) mem_ready = (mcnt >= v.mw);
      else                    mem_ready = 1'b1;
      #2;
      cyc++;
      if (state == 3'd0) fcnt++;
      if (state == 3'd3) mcnt++;
      pcw += int'(PCWrite);
      rw  += int'(RegWrite);
      if (instr_done || err) begin
        dn = int'(instr_done);
        er = int'(err);
        src = int'(PCSrc);
        fin = 1;
      end
      tick();
    end
    check({v.name, "_cycles"}, cyc, v.cyc);
    check({v.name, "_pcwrite"}, pcw, v.pcw);
    check({v.name, "_regwrite"}, rw, v.rw);
    check({v.name, "_done"}, dn, v.dn);
    check({v.name, "_err"}, er, v.er);
    check({v.name, "_pcsrc"}, src, v.src);
  endtask

  initial begin
    vec_t vt[16];
    logic [14:0] st_trace;
    logic [4:0]  rw_trace, dn_trace;
    int          guard;

    //          name        op     fn     z fw  mw  cyc pcw rw dn er src
    vt[0]  = mkv("add",     6'd0,  6'd32, 0, 0,  0,  4,  1, 1, 1, 0, 0);
    vt[1]  = mkv("lw_w3",   6'd35, 6'd0,  0, 0,  3,  8,  1, 1, 1, 0, 0);
    vt[2]  = mkv("sw_w",    6'd43, 6'd0,  0, 1,  2,  7,  1, 0, 1, 0, 0);
    vt[3]  = mkv("beq_t",   6'd4,  6'd0,  1, 0,  0,  3,  2, 0, 1, 0, 1);
    vt[4]  = mkv("beq_nt",  6'd4,  6'd0,  0, 0,  0,  3,  1, 0, 1, 0, 1);
    vt[5]  = mkv("bne_t",   6'd5,  6'd0,  0, 0,  0,  3,  2, 0, 1, 0, 1);
    vt[6]  = mkv("jal",     6'd3,  6'd0,  0, 0,  0,  2,  2, 1, 1, 0, 2);
    vt[7]  = mkv("jr",      6'd0,  6'd8,  0, 0,  0,  2,  2, 0, 1, 0, 3);
    vt[8]  = mkv("jmp",     6'd2,  6'd0,  0, 0,  0,  2,  2, 0, 1, 0, 2);
    vt[9]  = mkv("ill_3f",  6'd63, 6'd0,  0, 0,  0,  2,  1, 0, 0, 1, 0);
    vt[10] = mkv("addi",    6'd8,  6'd0,  0, 0,  0,  4,  1, 1, 1, 0, 0);
    vt[11] = mkv("fetch_to",6'd2,  6'd0,  0, 20, 0,  15, 0, 0, 0, 1, 0);
    vt[12] = mkv("lw_to",   6'd35, 6'd0,  0, 0,  20, 18, 1, 0, 0, 1, 0);
    vt[13] = mkv("sw_lim",  6'd43, 6'd0,  0, 0,  14, 18, 1, 0, 1, 0, 0);
    vt[14] = mkv("jmp_lim", 6'd2,  6'd0,  0, 14, 0,  16, 2, 0, 1, 0, 2);
    vt[15] = mkv("ill_06",  6'd6,  6'd0,  0, 0,  0,  2,  1, 0, 0, 1, 0);

    // reset state, with mem_ready high so any leak of IRWrite/PCWrite shows
    reset = 1'b1; mem_ready = 1'b1; Opcode = 6'd0; Function_opcode = 6'd32; Zero = 1'b0;
    #3;
    check("reset_outputs", {20'd0, outv()}, {20'd0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0)});
    tick();
    check("reset_hold_edge", {20'd0, outv()}, {20'd0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0)});
`ifdef SEQ_PERF_CNT_EN
    check("reset_cycle_count", cycle_count, 32'd0);
    check("reset_instr_count", instr_count, 32'd0);
`endif
    reset = 1'b0;

    // add with mem_ready held 1: states 0,1,2,4,0; RegWrite and done only in WB
    st_trace = '0; rw_trace = '0; dn_trace = '0;
    for (int c = 0; c < 5; c++) begin
      #2;
      st_trace = {st_trace[11:0], state};
      rw_trace = {rw_trace[3:0], RegWrite};
      dn_trace = {dn_trace[3:0], instr_done};
      if (c < 4) tick();
    end
    check("add_states", {17'd0, st_trace}, {17'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0});
    check("add_regwrite", {27'd0, rw_trace}, 32'b00010);
    check("add_done", {27'd0, dn_trace}, 32'b00010);
    tick();  // leave the FETCH cycle sampled above with mem_ready 1 -> DECODE
    // finish that instruction (still add) so the next test starts in FETCH
    guard = 0;
    while (state != 3'd0 && guard < 8) begin tick(); guard++; end
    check("add_return_fetch", {29'd0, state}, 32'd0);

    foreach (vt[i]) run_vec(vt[i]);

    // reset asserted in the MEM state of sw
    Opcode = 6'd43; Function_opcode = 6'd0; Zero = 1'b0;
    guard = 0;
    while (state != 3'd3 && guard < 10) begin
      mem_ready = 1'b1;
      #2;
      tick();
      guard++;
    end
    mem_ready = 1'b0;
    #2;
    check("sw_mem_state", {29'd0, state}, 32'd3);
    check("sw_mem_write", {31'd0, MemWrite}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_mem", {20'd0, outv()}, {20'd0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0)});
    mem_ready = 1'b1;
    #1;
    check("rst_mid_mem_ready", {20'd0, outv()}, {20'd0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0)});
`ifdef SEQ_PERF_CNT_EN
    check("rst_mid_cycle_count", cycle_count, 32'd0);
    check("rst_mid_instr_count", instr_count, 32'd0);
`endif
    tick();
    check("rst_mid_after_edge", {20'd0, outv()}, {20'd0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0)});
    reset = 1'b0;

    // directed model runs for the latency corners, then random instructions
    run_model(6'd35, 6'd0, 1'b0, 0, 3);
    run_model(6'd43, 6'd0, 1'b0, 2, 0);
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op, fn;
      int         sel, fw, mw;
      sel = int'($urandom_range(0, 11));
      fn = 6'($urandom_range(0, 63));
      case (sel)
        0, 1: op = 6'd0;
        2:  op = 6'd2;
        3:  op = 6'd3;
        4:  op = 6'd4;
        5:  op = 6'd5;
        6:  op = 6'd35;
        7:  op = 6'd43;
        8:  op = 6'(8 + $urandom_range(0, 7));
        9:  op = 6'($urandom_range(0, 63));
        10: begin op = 6'd0; fn = 6'd8; end
        default: op = 6'd35;
      endcase
      fw = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(13, 17));
      mw = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(13, 17));
      run_model(op, fn, 1'($urandom_range(0, 1)), fw, mw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
